// File: rtl/pattern_sram_loader.sv
// Pattern SRAM loader: streams host bytes into the pattern SRAM and publishes the
// last written address to pattern_gen. Loading is locked out while playback runs.
module pattern_sram_loader #(
   parameter int                ADDR_W   = 19,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] start_addr_load,
   input  logic              load_stop,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              pattern_active,
   input  logic [ADDR_W-1:0] sram_addr_pat_gen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_wdata,
   output logic              sram_we,
   output logic [23:0]       end_address_pat_gen,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_overflow,
   output logic [ADDR_W:0]   byte_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_req_t;

   logic [1:0]        state;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W:0]   count;
   logic [23:0]       end_addr;
   logic              full;
   logic              overflow_q;
   logic              stop_pend;
   wr_req_t           wr;

   logic in_load;
   logic start_ok;
   logic ready_c;
   logic accept;
   logic stop_now;
   logic at_max;

   // A stop that arrives during playback is held until playback ends, so the
   // published end address never moves while pattern_gen is reading it.
   always_comb begin
      in_load  = (state == S_LOAD);
      start_ok = load_start && !pattern_active;
      ready_c  = in_load && !pattern_active && !full && !stop_pend;
      accept   = byte_valid && ready_c;
      stop_now = in_load && !start_ok && !pattern_active && (load_stop || stop_pend);
      at_max   = (wptr == MAX_ADDR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wptr       <= '0;
         last_addr  <= '0;
         count      <= '0;
         end_addr   <= '0;
         full       <= 1'b0;
         overflow_q <= 1'b0;
         stop_pend  <= 1'b0;
         wr         <= '0;
      end else begin
         // The write is registered from the accept cycle and always completes,
         // even if the session restarts or closes in that same cycle.
         wr.vld <= accept;
         if (accept) begin
            wr.addr <= wptr;
            wr.data <= byte_data;
         end

         if (start_ok) begin
            state      <= S_LOAD;
            wptr       <= start_addr_load;
            count      <= '0;
            full       <= 1'b0;
            overflow_q <= 1'b0;
            stop_pend  <= 1'b0;
         end else if (in_load) begin
            if (accept) begin
               count     <= count + 1'b1;
               last_addr <= wptr;
               if (at_max) full <= 1'b1;
               else        wptr <= wptr + 1'b1;
            end
            if (byte_valid && full)
               overflow_q <= 1'b1;
            if (stop_now) begin
               state     <= S_DONE;
               stop_pend <= 1'b0;
               if (accept || count != '0)
                  end_addr <= 24'(accept ? wptr : last_addr);
            end else if (load_stop && pattern_active) begin
               stop_pend <= 1'b1;
            end
         end
      end
   end

   assign byte_ready          = ready_c;
   assign sram_we             = wr.vld;
   assign sram_wdata          = wr.data;
   assign sram_addr           = wr.vld ? wr.addr : (in_load ? wptr : sram_addr_pat_gen);
   assign end_address_pat_gen = end_addr;
   assign load_busy           = in_load;
   assign load_done           = (state == S_DONE);
   assign load_overflow       = overflow_q;
   assign byte_count          = count;

endmodule

// File: tb/tb_pattern_sram_loader.sv
// Directed bench for pattern_sram_loader: expected SRAM writes go to a scoreboard
// queue, a negedge monitor pops and compares them; status is checked inline.
module tb_pattern_sram_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start;
   logic [18:0] start_addr_load;
   logic        load_stop;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        pattern_active;
   logic [18:0] sram_addr_pat_gen;
   logic [18:0] sram_addr;
   logic [7:0]  sram_wdata;
   logic        sram_we;
   logic [23:0] end_address_pat_gen;
   logic        load_busy;
   logic        load_done;
   logic        load_overflow;
   logic [19:0] byte_count;

   typedef struct {
      logic [18:0] a;
      logic [7:0]  d;
      int          c;
   } wr_t;

   wr_t q[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;

   pattern_sram_loader dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .start_addr_load(start_addr_load),
      .load_stop(load_stop), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .pattern_active(pattern_active),
      .sram_addr_pat_gen(sram_addr_pat_gen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_we(sram_we),
      .end_address_pat_gen(end_address_pat_gen), .load_busy(load_busy),
      .load_done(load_done), .load_overflow(load_overflow),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] d, input logic [18:0] a);
      byte_valid = 1'b1;
      byte_data  = d;
      #0;
      check("byte_ready_on_issue", 32'(byte_ready), 32'd1);
      q.push_back('{a: a, d: d, c: cyc + 1});
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic [18:0] a);
      load_start      = 1'b1;
      start_addr_load = a;
      tick();
      load_start = 1'b0;
   endtask

   task automatic pulse_stop();
      load_stop = 1'b1;
      tick();
      load_stop = 1'b0;
   endtask

   task automatic check_reset_vals();
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_sram_we", 32'(sram_we), 32'd0);
      check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'(sram_addr_pat_gen));
      check("rst_end_addr", 32'(end_address_pat_gen), 32'd0);
      check("rst_load_busy", 32'(load_busy), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_overflow", 32'(load_overflow), 32'd0);
      check("rst_byte_count", 32'(byte_count), 32'd0);
   endtask

   // Scoreboard monitor: every write must match the next expected one, cycle included.
   always @(negedge clk) begin
      if (sram_we) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, expected none",
                     sram_addr, sram_wdata, cyc);
         end else begin
            wr_t e;
            e = q.pop_front();
            check("write_addr", 32'(sram_addr), 32'(e.a));
            check("write_data", 32'(sram_wdata), 32'(e.d));
            check("write_cycle", 32'(cyc), 32'(e.c));
         end
      end else if (!load_busy) begin
         check("mux_follows_pat_gen", 32'(sram_addr), 32'(sram_addr_pat_gen));
      end
   end

   initial begin
      rst_n = 1'b0; load_start = 1'b0; start_addr_load = '0; load_stop = 1'b0;
      byte_valid = 1'b0; byte_data = '0; pattern_active = 1'b0;
      sram_addr_pat_gen = 19'h00005;
      tick(); tick();
      check_reset_vals();
      rst_n = 1'b1;
      tick();

      // Normal load
      pulse_start(19'h00010);
      check("start_busy", 32'(load_busy), 32'd1);
      check("start_count", 32'(byte_count), 32'd0);
      issue(8'hA5, 19'h00010);
      issue(8'h3C, 19'h00011);
      issue(8'hFF, 19'h00012);
      pulse_stop();
      check("normal_done", 32'(load_done), 32'd1);
      check("normal_busy", 32'(load_busy), 32'd0);
      check("normal_count", 32'(byte_count), 32'd3);
      check("normal_end", 32'(end_address_pat_gen), 32'h000012);

      // Empty session keeps the previous end address
      pulse_start(19'h00040);
      check("empty_done_cleared", 32'(load_done), 32'd0);
      pulse_stop();
      check("empty_end", 32'(end_address_pat_gen), 32'h000012);
      check("empty_done", 32'(load_done), 32'd1);
      check("empty_count", 32'(byte_count), 32'd0);

      // Full: no wrap, third byte dropped with overflow
      pulse_start(19'h7FFFE);
      issue(8'h11, 19'h7FFFE);
      issue(8'h22, 19'h7FFFF);
      check("full_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b1; byte_data = 8'h33;
      tick();
      byte_valid = 1'b0;
      check("full_overflow", 32'(load_overflow), 32'd1);
      check("full_count", 32'(byte_count), 32'd2);
      check("full_ready_after", 32'(byte_ready), 32'd0);
      pulse_stop();
      check("full_end", 32'(end_address_pat_gen), 32'h07FFFF);

      // Playback lockout: start ignored, mux follows pattern_gen
      pattern_active = 1'b1;
      pulse_start(19'h00100);
      check("lock_busy", 32'(load_busy), 32'd0);
      check("lock_done_kept", 32'(load_done), 32'd1);
      check("lock_ovf_kept", 32'(load_overflow), 32'd1);
      check("lock_mux_5", 32'(sram_addr), 32'h00005);
      sram_addr_pat_gen = 19'h00123;
      tick();
      check("lock_mux_123", 32'(sram_addr), 32'h00123);
      pattern_active = 1'b0;

      // Stall mid-session
      pulse_start(19'h00200);
      check("stall_ovf_cleared", 32'(load_overflow), 32'd0);
      issue(8'h01, 19'h00200);
      pattern_active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1'b1; byte_data = 8'h02;
         #0;
         check("stall_ready", 32'(byte_ready), 32'd0);
         tick();
      end
      check("stall_busy", 32'(load_busy), 32'd1);
      check("stall_end_stable", 32'(end_address_pat_gen), 32'h07FFFF);
      pattern_active = 1'b0;
      issue(8'h02, 19'h00201);
      pulse_stop();
      check("stall_end", 32'(end_address_pat_gen), 32'h000201);
      check("stall_count", 32'(byte_count), 32'd2);

      // Accept and stop together
      pulse_start(19'h00300);
      issue(8'h55, 19'h00300);
      load_stop = 1'b1;
      issue(8'h66, 19'h00301);
      load_stop = 1'b0;
      check("accstop_done", 32'(load_done), 32'd1);
      check("accstop_end", 32'(end_address_pat_gen), 32'h000301);
      check("accstop_count", 32'(byte_count), 32'd2);

      // Start and stop together: start wins
      load_start = 1'b1; load_stop = 1'b1; start_addr_load = 19'h00400;
      tick();
      load_start = 1'b0; load_stop = 1'b0;
      check("startstop_busy", 32'(load_busy), 32'd1);
      check("startstop_done", 32'(load_done), 32'd0);
      check("startstop_count", 32'(byte_count), 32'd0);
      issue(8'h77, 19'h00400);
      pulse_stop();
      check("startstop_end", 32'(end_address_pat_gen), 32'h000400);

      // Reset during a back-to-back stream
      pulse_start(19'h00500);
      issue(8'h80, 19'h00500);
      issue(8'h81, 19'h00501);
      byte_valid = 1'b1; byte_data = 8'h82; rst_n = 1'b0;
      tick();
      byte_valid = 1'b0;
      check_reset_vals();
      tick();
      rst_n = 1'b1;
      tick(); tick();

      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
